// File: rtl/arb2_4.sv
// arb2_4: round-robin 2-requester channel arbiter with registered mux data; ARB_TIMEOUT_EN adds MAX_HOLD forced handoff
module arb2_4 #(
  parameter int WIDTH = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state, nxt;
  logic last_b, expired;
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("MAX_HOLD must be >= 2");
  end
`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD) + 1;
  logic [HW-1:0] hold;
  assign expired = hold == HW'(MAX_HOLD - 1);
  always_ff @(posedge clk)
    if (!rst_n || nxt != state) hold <= '0;
    else if (state != IDLE && !expired) hold <= hold + HW'(1);
`else
  assign expired = 1'b0;
`endif
  always_comb
    nxt = state == OWN_A ? (req_a && !(expired && req_b) ? OWN_A : req_b ? OWN_B : IDLE) :
          state == OWN_B ? (req_b && !(expired && req_a) ? OWN_B : req_a ? OWN_A : IDLE) :
          (req_a && (!req_b || last_b) ? OWN_A : req_b ? OWN_B : IDLE);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      busy <= 1'b0;
      sel <= 1'b0;
      out <= '0;
      out_valid <= 1'b0;
      last_b <= 1'b1;
    end else begin
      state <= nxt;
      gnt_a <= nxt == OWN_A;
      gnt_b <= nxt == OWN_B;
      busy <= nxt != IDLE;
      sel <= nxt == OWN_A ? 1'b0 : nxt == OWN_B ? 1'b1 : sel;
      out <= state == OWN_A ? a : state == OWN_B ? b : out;
      out_valid <= state == OWN_A || state == OWN_B;
      last_b <= state == OWN_A && nxt != OWN_A ? 1'b0 : state == OWN_B && nxt != OWN_B ? 1'b1 : last_b;
    end
endmodule
